// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/fetch sequencer and its neighbours.
//   pc_state_e     : fetch sequencer states
//   AddrMsb/ImmMsb : instruction field positions (jump target, immediate)
//   DefaultResetPc : default PC loaded on reset
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StFault = 2'd3
    } pc_state_e;

    localparam int unsigned AddrMsb        = 25;
    localparam int unsigned ImmMsb         = 15;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : fetch address (master -> slave)
//   imem_ack   : request accepted, imem_rdata valid this cycle (slave -> master)
//   imem_rdata : instruction word (slave -> master)
interface pc_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_instr_fields.sv
// Combinational split of an instruction word into its jump-target and immediate fields.
//   instr_i : low instruction bits [AddrMsb:0] (upper opcode bits are not needed here)
//   addr_o  : jump target field
//   imm_o   : immediate field
module pc_fetch_instr_fields
    import pc_fetch_pkg::*;
(
    input  logic [AddrMsb:0] instr_i,
    output logic [AddrMsb:0] addr_o,
    output logic [ImmMsb:0]  imm_o
);

    always_comb begin
        addr_o = instr_i;
        imm_o  = instr_i[ImmMsb:0];
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   imem         : instruction-memory fetch bus (master side)
//   advance      : core retires current instruction, load new_pc
//   new_pc       : next PC from the next-PC calculator
//   pc           : current PC (old_PC to the calculator)
//   instr        : latched instruction word
//   addr, imm    : jump-target / immediate fields of instr
//   instr_valid  : instr/addr/imm belong to pc
//   fault        : sticky fetch timeout or misaligned new_pc
// All outputs are registers or decodes of the state register only.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_fetch_if.master         imem,
    input  logic               advance,
    input  logic [31:0]        new_pc,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic [AddrMsb:0]   addr,
    output logic [ImmMsb:0]    imm,
    output logic               instr_valid,
    output logic               fault
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    pc_state_e        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    count_d = '0;
                    state_d = StHold;
                end else if (TIMEOUT != 0) begin
                    // Leaving on the TIMEOUT-th idle cycle keeps the count saturated.
                    count_d = count_q + CNT_W'(1);
                    if (count_d == TimeoutCnt) begin
                        state_d = StFault;
                    end
                end
            end
            StHold: begin
                if (advance) begin
                    if (new_pc[1:0] == 2'b00) begin
                        pc_d    = new_pc;
                        state_d = StFetch;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state_q == StFetch);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == StHold);
        fault          = (state_q == StFault);
        pc             = pc_q;
        instr          = instr_q;
    end

    pc_fetch_instr_fields u_instr_fields (
        .instr_i (instr_q[AddrMsb:0]),
        .addr_o  (addr),
        .imm_o   (imm)
    );

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned TIMEOUT  = 6;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        advance;
    logic [31:0] new_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [25:0] addr;
    logic [15:0] imm;
    logic        instr_valid;
    logic        fault;

    pc_fetch_if imem_bus ();

    pc_fetch #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (imem_bus),
        .advance     (advance),
        .new_pc      (new_pc),
        .pc          (pc),
        .instr       (instr),
        .addr        (addr),
        .imm         (imm),
        .instr_valid (instr_valid),
        .fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: architectural PC, sticky fault, pending fetches.
    exp_t        sb[$];
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic        mon_en;
    logic        prev_valid;
    logic [31:0] cur_data;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle against the model; pop on each new instr_valid.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n || !mon_en) begin
            prev_valid <= 1'b0;
        end else begin
            check("pc", pc, exp_pc);
            check("fault", 32'(fault), 32'(exp_fault));
            if (imem_bus.imem_req) begin
                check("imem_addr", imem_bus.imem_addr, exp_pc);
                check("valid_during_fetch", 32'(instr_valid), 32'd0);
            end
            if (instr_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got instr %h expected no new instruction", instr);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_instr", instr, e.data);
                    check("sb_addr", 32'(addr), 32'(e.data[25:0]));
                    check("sb_imm", 32'(imm), 32'(e.data[15:0]));
                    cur_data <= e.data;
                end
            end else if (instr_valid) begin
                check("instr_hold", instr, cur_data);
            end
            prev_valid <= instr_valid;
        end
    end

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        step();
        #2;
        reset_n = 1'b0;
        exp_pc = RESET_PC;
        exp_fault = 1'b0;
        sb.delete();
        #1;
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        imem_bus.imem_ack = 1'b0;
        advance = 1'b0;
        step();
        step();
        #1;
        reset_n = 1'b1;
        mon_en = 1'b1;
        #1;
        check("idle_req", 32'(imem_bus.imem_req), 32'd0);
        check("idle_pc", pc, RESET_PC);
        step();
        check("first_req", 32'(imem_bus.imem_req), 32'd1);
        check("first_addr", imem_bus.imem_addr, RESET_PC);
    endtask

    // Respond to a fetch after 'delay' unacknowledged request cycles.
    task automatic do_fetch(input int delay, input logic [31:0] data);
        logic [31:0] r;
        for (int i = 0; i < 4 && !imem_bus.imem_req; i++) step();
        check("fetch_req_seen", 32'(imem_bus.imem_req), 32'd1);
        for (int i = 0; i < delay; i++) begin
            r = $urandom();
            advance = r[0];            // ignored outside HOLD
            new_pc = {r[31:2], 2'b00};
            step();
        end
        advance = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = data;
        sb.push_back('{pc: exp_pc, data: data});
        step();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic do_advance(input logic [31:0] npc, input int hold);
        logic [31:0] r;
        for (int i = 0; i < hold; i++) begin
            r = $urandom();
            imem_bus.imem_ack = r[0];  // ignored outside FETCH
            imem_bus.imem_rdata = $urandom();
            step();
        end
        imem_bus.imem_ack = 1'b0;
        advance = 1'b1;
        new_pc = npc;
        step();
        advance = 1'b0;
        if (npc[1:0] == 2'b00) exp_pc = npc;
        else exp_fault = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        n_checks = 0;
        n_fail = 0;
        mon_en = 1'b0;
        reset_n = 1'b1;
        advance = 1'b0;
        new_pc = '0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = '0;
        exp_pc = RESET_PC;
        exp_fault = 1'b0;
        cur_data = '0;

        // Reset and first request.
        do_reset();

        // Single-cycle fetch, field split, aligned advance.
        do_fetch(0, 32'h0800_0010);
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_addr", 32'(addr), 32'h0000_0010);
        check("t2_imm", 32'(imm), 32'h0000_0010);
        do_advance(32'h0000_0040, 0);
        check("t2_pc", pc, 32'h0000_0040);
        check("t2_valid_clr", 32'(instr_valid), 32'd0);
        check("t2_req", 32'(imem_bus.imem_req), 32'd1);
        check("t2_imem_addr", imem_bus.imem_addr, 32'h0000_0040);

        // Ack on the last request cycle before timeout.
        do_fetch(TIMEOUT - 1, 32'hDEAD_BEEF);
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_fault", 32'(fault), 32'd0);
        do_advance(32'h0000_1000, 1);

        // Randomized fetch/retire traffic.
        for (int n = 0; n < 40; n++) begin
            do_fetch(int'($urandom_range(0, TIMEOUT - 1)), $urandom());
            r = $urandom();
            do_advance({r[31:2], 2'b00}, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a fetch, then restart.
        step();
        do_reset();
        do_fetch(1, 32'h1234_5678);
        do_advance(32'h0000_0100, 0);

        // Misaligned new_pc faults and keeps pc.
        do_fetch(2, 32'hCAFE_F00D);
        r = exp_pc;
        do_advance(32'h0000_0042, 0);
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_pc", pc, r);
        check("t5_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        do_reset();

        // Timeout with no ack; fault is sticky until reset.
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            step();
            if (i == int'(TIMEOUT) - 1) begin
                check("t4_pre_req", 32'(imem_bus.imem_req), 32'd1);
                check("t4_pre_fault", 32'(fault), 32'd0);
            end
        end
        exp_fault = 1'b1;
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_req", 32'(imem_bus.imem_req), 32'd0);
        check("t4_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            imem_bus.imem_ack = 1'b1;
            imem_bus.imem_rdata = r;
            advance = 1'b1;
            new_pc = {r[31:2], 2'b00};
            step();
        end
        imem_bus.imem_ack = 1'b0;
        advance = 1'b0;
        check("t4_sticky_fault", 32'(fault), 32'd1);
        check("t4_sticky_req", 32'(imem_bus.imem_req), 32'd0);
        do_reset();
        check("t4_cleared", 32'(fault), 32'd0);

        do_fetch(0, 32'h0BAD_CAFE);
        do_advance(32'h0000_0200, 0);
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
